// File: rtl/matmul_host_seq.sv
// Host-side sequencer for the 2x2 matrix multiplier tile: collects A/B operand bytes,
// range-checks them, drives the multiplier, and streams the four result nibbles back.
module matmul_host_seq #(
    parameter int unsigned ELEM_W  = 2,
    parameter int unsigned MAX_VAL = 2,
    parameter int unsigned RES_W   = 4,
    parameter int unsigned LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*ELEM_W-1:0]   in_data,
    output logic [4*ELEM_W-1:0]   mm_a,
    output logic [4*ELEM_W-1:0]   mm_b,
    output logic                  mm_ena,
    input  logic [2*RES_W-1:0]    mm_c_lo,
    input  logic [2*RES_W-1:0]    mm_c_hi,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RES_W-1:0]      out_data,
    output logic [1:0]            out_idx,
    output logic                  out_last,
    output logic                  err,
    output logic [7:0]            err_cnt,
    output logic                  busy
);

    localparam int unsigned OP_W  = 4 * ELEM_W;
    localparam int unsigned RES4W = 4 * RES_W;
    localparam int unsigned CNT_W = $clog2(LAT + 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_B,
        CHECK,
        WAIT,
        SEND
    } state_t;

    state_t             state_q, state_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES4W-1:0]   res_q, res_d;

    logic               in_ready_d;
    logic [OP_W-1:0]    mm_a_d, mm_b_d;
    logic               mm_ena_d;
    logic               out_valid_d;
    logic [RES_W-1:0]   out_data_d;
    logic [1:0]         out_idx_d;
    logic               out_last_d;
    logic               err_d;
    logic [7:0]         err_cnt_d;
    logic               busy_d;

    logic               range_bad;
    logic [1:0]         idx_next;

    // Any of the eight captured operand elements above the legal maximum
    always_comb begin
        range_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (32'(a_q[i*ELEM_W +: ELEM_W]) > MAX_VAL) range_bad = 1'b1;
            if (32'(b_q[i*ELEM_W +: ELEM_W]) > MAX_VAL) range_bad = 1'b1;
        end
    end

    assign idx_next = out_idx + 2'd1;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        mm_a_d      = mm_a;
        mm_b_d      = mm_b;
        mm_ena_d    = mm_ena;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_idx_d   = out_idx;
        out_last_d  = out_last;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_data;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (in_valid && in_ready) begin
                    b_d     = in_data;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (range_bad) begin
                    err_d = 1'b1;
                    if (err_cnt != 8'hFF) err_cnt_d = err_cnt + 8'd1;
                    state_d = IDLE;
                end else begin
                    mm_a_d   = a_q;
                    mm_b_d   = b_q;
                    mm_ena_d = 1'b1;
                    cnt_d    = CNT_W'(LAT + 1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_d       = {mm_c_hi, mm_c_lo};
                    mm_ena_d    = 1'b0;
                    out_valid_d = 1'b1;
                    out_idx_d   = 2'd0;
                    out_data_d  = mm_c_lo[RES_W-1:0];
                    out_last_d  = 1'b0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (out_valid && out_ready) begin
                    if (out_idx == 2'd3) begin
                        out_valid_d = 1'b0;
                        out_idx_d   = 2'd0;
                        out_data_d  = '0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        out_idx_d  = idx_next;
                        out_data_d = res_q[int'(idx_next)*RES_W +: RES_W];
                        out_last_d = (idx_next == 2'd3);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE) || (state_d == LOAD_B);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            in_ready  <= 1'b0;
            mm_a      <= '0;
            mm_b      <= '0;
            mm_ena    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= 2'd0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            in_ready  <= in_ready_d;
            mm_a      <= mm_a_d;
            mm_b      <= mm_b_d;
            mm_ena    <= mm_ena_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_idx   <= out_idx_d;
            out_last  <= out_last_d;
            err       <= err_d;
            err_cnt   <= err_cnt_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_matmul_host_seq.sv
// Directed self-checking bench for matmul_host_seq with a one-register 2x2 multiplier model.
module tb_matmul_host_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [7:0] mm_a, mm_b;
    logic       mm_ena;
    logic [7:0] mm_c_lo, mm_c_hi;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic [1:0] out_idx;
    logic       out_last;
    logic       err;
    logic [7:0] err_cnt;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] got_data [4];
    logic [1:0] got_idx  [4];
    logic       got_last [4];
    logic       got_valid[4];
    bit         recv_to;

    always #5 clk = ~clk;

    matmul_host_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_ena    (mm_ena),
        .mm_c_lo   (mm_c_lo),
        .mm_c_hi   (mm_c_hi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .err       (err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    // Multiplier tile model: one register stage, updates only while enabled
    function automatic logic [3:0] el(input logic [7:0] p, input int i);
        return 4'(p[2*i +: 2]);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            mm_c_lo <= 8'h00;
            mm_c_hi <= 8'h00;
        end else if (mm_ena) begin
            mm_c_lo[3:0] <= el(mm_a,0)*el(mm_b,0) + el(mm_a,1)*el(mm_b,2);
            mm_c_lo[7:4] <= el(mm_a,0)*el(mm_b,1) + el(mm_a,1)*el(mm_b,3);
            mm_c_hi[3:0] <= el(mm_a,2)*el(mm_b,0) + el(mm_a,3)*el(mm_b,2);
            mm_c_hi[7:4] <= el(mm_a,2)*el(mm_b,1) + el(mm_a,3)*el(mm_b,3);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL send_byte: in_ready stayed 0 for byte %h, required 1", d);
        end
    endtask

    task automatic recv_result();
        out_ready = 1'b1;
        recv_to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                recv_to = 1'b0;
                break;
            end
            tick();
        end
        for (int b = 0; b < 4; b++) begin
            got_valid[b] = out_valid;
            got_data[b]  = out_data;
            got_idx[b]   = out_idx;
            got_last[b]  = out_last;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({in_ready, mm_a, mm_b, mm_ena, out_valid, out_data, out_idx, out_last, err, err_cnt, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got in_ready=%b mm_a=%h mm_b=%h ena=%b ov=%b od=%h idx=%0d last=%b err=%b cnt=%0d busy=%b, required all 0",
                     in_ready, mm_a, mm_b, mm_ena, out_valid, out_data, out_idx, out_last, err, err_cnt, busy);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({in_ready, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_idle: got in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_identity();
        logic [3:0] exp_d [4] = '{4'd2, 4'd1, 4'd0, 4'd2};
        int ena_cycles;
        bit seen;
        ena_cycles = 0;
        seen = 1'b0;
        send_byte(8'h41);
        send_byte(8'h86);
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            if (mm_ena) begin
                ena_cycles++;
                if (!seen) begin
                    seen = 1'b1;
                    n_cmp++;
                    if ({mm_a, mm_b} !== 16'h4186) begin
                        n_bad++;
                        $display("FAIL ident_operands: got mm_a=%h mm_b=%h, required 41 86", mm_a, mm_b);
                    end
                end
            end
            tick();
        end
        n_cmp++;
        if (ena_cycles != 2) begin
            n_bad++;
            $display("FAIL ident_ena_cycles: got %0d, required 2", ena_cycles);
        end
        recv_result();
        n_cmp++;
        if (recv_to) begin
            n_bad++;
            $display("FAIL ident_timeout: out_valid never rose, required 1");
        end
        for (int b = 0; b < 4; b++) begin
            n_cmp++;
            if ({got_valid[b], got_idx[b], got_data[b], got_last[b]} !== {1'b1, 2'(b), exp_d[b], (b == 3)}) begin
                n_bad++;
                $display("FAIL ident_beat%0d: got v=%b idx=%0d data=%0d last=%b, required 1 %0d %0d %b",
                         b, got_valid[b], got_idx[b], got_data[b], got_last[b], b, exp_d[b], (b == 3));
            end
        end
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL ident_done: got ov=%b busy=%b in_ready=%b, required 0 0 1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        send_byte(8'hAA);
        send_byte(8'hAA);
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_busy_send: got %b, required 1", busy);
        end
        recv_result();
        for (int b = 0; b < 4; b++) begin
            n_cmp++;
            if ({got_valid[b], got_idx[b], got_data[b], got_last[b]} !== {1'b1, 2'(b), 4'd8, (b == 3)}) begin
                n_bad++;
                $display("FAIL b2b_beat%0d: got v=%b idx=%0d data=%0d last=%b, required 1 %0d 8 %b",
                         b, got_valid[b], got_idx[b], got_data[b], got_last[b], b, (b == 3));
            end
        end
        n_cmp++;
        if ({busy, out_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_busy_fall: got busy=%b ov=%b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_bad_range();
        send_byte(8'h03);
        send_byte(8'h00);
        n_cmp++;
        if ({err, in_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL bad_check_cycle: got err=%b in_ready=%b, required 0 0", err, in_ready);
        end
        tick();
        n_cmp++;
        if ({err, err_cnt, in_ready, mm_ena, busy, mm_a} !== {1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 8'hAA}) begin
            n_bad++;
            $display("FAIL bad_err_pulse: got err=%b cnt=%0d in_ready=%b ena=%b busy=%b mm_a=%h, required 1 1 1 0 0 aa",
                     err, err_cnt, in_ready, mm_ena, busy, mm_a);
        end
        tick();
        n_cmp++;
        if ({err, err_cnt, mm_ena} !== {1'b0, 8'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL bad_err_end: got err=%b cnt=%0d ena=%b, required 0 1 0", err, err_cnt, mm_ena);
        end
    endtask

    task automatic test_stall();
        logic [3:0] exp_d [4] = '{4'd2, 4'd1, 4'd0, 4'd2};
        bit seen;
        seen = 1'b0;
        out_ready = 1'b0;
        send_byte(8'h41);
        send_byte(8'h86);
        for (int k = 0; k < 20; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!seen || {out_idx, out_data} !== {2'd0, 4'd2}) begin
            n_bad++;
            $display("FAIL stall_first: got ov=%b idx=%0d data=%0d, required 1 0 2", out_valid, out_idx, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if ({out_valid, out_idx, out_data, out_last, in_ready} !== {1'b1, 2'd1, 4'd1, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL stall_hold%0d: got ov=%b idx=%0d data=%0d last=%b in_ready=%b, required 1 1 1 0 0",
                         k, out_valid, out_idx, out_data, out_last, in_ready);
            end
        end
        out_ready = 1'b1;
        for (int b = 1; b < 4; b++) begin
            n_cmp++;
            if ({out_valid, out_idx, out_data, out_last, in_ready} !== {1'b1, 2'(b), exp_d[b], (b == 3), 1'b0}) begin
                n_bad++;
                $display("FAIL stall_beat%0d: got ov=%b idx=%0d data=%0d last=%b in_ready=%b, required 1 %0d %0d %b 0",
                         b, out_valid, out_idx, out_data, out_last, in_ready, b, exp_d[b], (b == 3));
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL stall_done: got ov=%b busy=%b in_ready=%b, required 0 0 1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset_wait();
        send_byte(8'hAA);
        send_byte(8'hAA);
        tick();
        n_cmp++;
        if (mm_ena !== 1'b1) begin
            n_bad++;
            $display("FAIL rstw_in_wait: got mm_ena=%b, required 1", mm_ena);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({in_ready, mm_a, mm_b, mm_ena, out_valid, out_data, out_idx, out_last, err, err_cnt, busy} !== '0) begin
            n_bad++;
            $display("FAIL rstw_outputs: got in_ready=%b mm_a=%h mm_b=%h ena=%b ov=%b od=%h idx=%0d last=%b err=%b cnt=%0d busy=%b, required all 0",
                     in_ready, mm_a, mm_b, mm_ena, out_valid, out_data, out_idx, out_last, err, err_cnt, busy);
        end
        reset = 1'b0;
        tick();
        send_byte(8'hAA);
        send_byte(8'hAA);
        recv_result();
        for (int b = 0; b < 4; b++) begin
            n_cmp++;
            if ({got_valid[b], got_idx[b], got_data[b], got_last[b]} !== {1'b1, 2'(b), 4'd8, (b == 3)}) begin
                n_bad++;
                $display("FAIL rstw_beat%0d: got v=%b idx=%0d data=%0d last=%b, required 1 %0d 8 %b",
                         b, got_valid[b], got_idx[b], got_data[b], got_last[b], b, (b == 3));
            end
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_d [4] = '{4'd2, 4'd1, 4'd0, 4'd2};
        for (int i = 0; i < 254; i++) begin
            send_byte(8'hFF);
            send_byte(8'h00);
        end
        tick();
        n_cmp++;
        if (err_cnt !== 8'd254) begin
            n_bad++;
            $display("FAIL sat_254: got err_cnt=%0d, required 254", err_cnt);
        end
        for (int i = 254; i < 300; i++) begin
            send_byte(8'hFF);
            send_byte(8'h00);
        end
        tick();
        n_cmp++;
        if ({err, err_cnt} !== {1'b1, 8'd255}) begin
            n_bad++;
            $display("FAIL sat_300: got err=%b err_cnt=%0d, required 1 255", err, err_cnt);
        end
        send_byte(8'h41);
        send_byte(8'h86);
        recv_result();
        for (int b = 0; b < 4; b++) begin
            n_cmp++;
            if ({got_valid[b], got_idx[b], got_data[b], got_last[b]} !== {1'b1, 2'(b), exp_d[b], (b == 3)}) begin
                n_bad++;
                $display("FAIL sat_good_beat%0d: got v=%b idx=%0d data=%0d last=%b, required 1 %0d %0d %b",
                         b, got_valid[b], got_idx[b], got_data[b], got_last[b], b, exp_d[b], (b == 3));
            end
        end
        n_cmp++;
        if ({err, err_cnt} !== {1'b0, 8'd255}) begin
            n_bad++;
            $display("FAIL sat_after_good: got err=%b err_cnt=%0d, required 0 255", err, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_back_to_back();
        test_bad_range();
        test_stall();
        test_reset_wait();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matmul_host_seq.md
Name: matmul_host_seq

Overview:
- Host-side sequencer for the 2x2 matrix multiplier tile; it is the initiator that feeds operands and reads results back.
- Accepts operand bytes over a valid/ready byte stream and range-checks every element.
- Drives the multiplier's packed A/B operand buses and enable, waits out the multiplier latency, and captures the packed C result.
- Returns the four result elements as a 4-beat valid/ready nibble stream.

Parameters:
- ELEM_W, 2, width of each operand element
- MAX_VAL, 2, largest legal operand element value
- RES_W, 4, width of each result element
- LAT, 1, multiplier register latency in clocks from operand change to valid C

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand byte valid
- in_ready  out  1  operand byte accepted when in_valid & in_ready
- in_data  in  8  packed operand byte: [1:0]=x11, [3:2]=x12, [5:4]=x21, [7:6]=x22
- mm_a  out  8  packed A to multiplier (same packing)
- mm_b  out  8  packed B to multiplier (same packing)
- mm_ena  out  1  multiplier enable
- mm_c_lo  in  8  multiplier result: [3:0]=c11, [7:4]=c12
- mm_c_hi  in  8  multiplier result: [3:0]=c21, [7:4]=c22
- out_valid  out  1  result nibble valid
- out_ready  in  1  downstream ready
- out_data  out  4  result element
- out_idx  out  2  element index: 0=c11, 1=c12, 2=c21, 3=c22
- out_last  out  1  high with idx 3
- err  out  1  one-cycle pulse, range error
- err_cnt  out  8  saturating range-error count
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high; single clk):
  - All outputs 0 and state IDLE; err_cnt cleared.
  - Reset in any state aborts the operation and discards captured data.
- FSM states: IDLE, LOAD_B, CHECK, WAIT, SEND.
- IDLE: in_ready=1. On handshake, store the byte as A and go to LOAD_B.
- LOAD_B: in_ready=1. On handshake, store the byte as B and go to CHECK.
- in_ready=0 in CHECK, WAIT and SEND; no input is accepted there.
- CHECK (1 cycle): flag any of the 8 elements > MAX_VAL.
  - Bad: err=1 for the next cycle only; err_cnt+1, saturating at 255. Go to IDLE. mm_a, mm_b and mm_ena are not changed.
  - Good: register mm_a=A, mm_b=B, mm_ena=1 on the same edge. Load the wait counter with LAT+1 and go to WAIT.
- WAIT: decrement the counter each cycle.
  - On the edge where the counter goes 1->0, capture mm_c_lo and mm_c_hi into the result register, drive mm_ena=0 and go to SEND.
  - With LAT=1, capture happens on the 2nd edge after the operands are registered.
- SEND:
  - out_valid=1; out_data = result element [out_idx].
  - out_idx starts at 0 and advances only on out_valid & out_ready.
  - out_last=1 when out_idx=3. The handshake on idx 3 returns the FSM to IDLE with out_valid=0 on the next cycle.
  - out_data, out_idx and out_last are held stable while out_ready=0.
- mm_a and mm_b hold their last values after mm_ena drops; they clear only on reset.
- Arithmetic: the block does no arithmetic. Result nibbles are passed through unchanged; the maximum legal value is 8 for MAX_VAL=2.
- Throughput: a new A byte is accepted the cycle after the last result handshake. There is no overlap between transactions.

Test Plan:
- A=0x41 (identity), B=0x86, bench multiplier model with LAT=1 -> mm_ena high for 2 cycles. Results 2,1,0,2 at idx 0..3; out_last on the 4th beat only.
- A=0xAA, B=0xAA, out_ready=1 constantly -> beats 8,8,8,8 on consecutive cycles. busy falls the cycle after the 4th beat.
- A=0x03 (a11=3), B=0x00 -> err pulses exactly 1 cycle; err_cnt=1; mm_ena never asserted; in_ready=1 two cycles after B is accepted.
- Identity case with out_ready=0 for 5 cycles at idx 1 -> out_data=1 and out_idx=1 held stable; in_valid held high is ignored (in_ready=0) until SEND completes.
- reset=1 for 1 cycle during WAIT -> every output 0 on the next cycle. A following A=0xAA, B=0xAA transaction returns 8,8,8,8 correctly.
- 300 back-to-back bad transactions (A=0xFF) -> err_cnt saturates at 255 and stays there. Then a good transaction completes normally with err_cnt unchanged.
